r200_divseq: RTL
================

R200_DIVSEQ -- requirements
Module: r200_divseq

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: execute stage presents a divide/remainder op this cycle.
REQ-005 SHALL have port func3, input, 3: instrn[14:12]; 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op1, input, 32: dividend.
REQ-007 SHALL have port op2, input, 32: divisor.
REQ-008 SHALL have port kill, input, 1: pipeline flush; abandons the current operation.
REQ-009 SHALL have port stall, output, 1: holds the execute stage while a division is in progress.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse; result is valid on this cycle.
REQ-012 SHALL have port result, output, 32: quotient or remainder.

Function
REQ-013 SHALL implement an FSM with states IDLE, PREP, ITER, FIX, DONE.
REQ-014 SHALL accept an op in IDLE when start=1, func3[2]=1 and kill=0, latching op1, op2 and func3 at that edge; func3[2]=0 SHALL be ignored, with no stall.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 Acceptance cycle T SHALL be followed by PREP at T+1, ITER at T+2..T+33 (32 cycles, 6-bit counter), FIX at T+34, DONE at T+35, then IDLE.
REQ-017 PREP SHALL form the magnitudes of the operands for DIV/REM (signed) and use the raw operands for DIVU/REMU.
REQ-018 Each ITER cycle SHALL perform one restoring shift-subtract step, producing one quotient bit, MSB first.
REQ-019 FIX SHALL negate the quotient when sign(op1) XOR sign(op2) for DIV, and negate the remainder when sign(op1) for REM.
REQ-020 Divide by zero (op2=0) SHALL go PREP -> DONE (done at T+2): quotient 0xFFFFFFFF, remainder = op1.
REQ-021 Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF) SHALL go PREP -> DONE (done at T+2): quotient 0x80000000, remainder 0.
REQ-022 stall SHALL be combinational: (IDLE & start & func3[2] & ~kill) | PREP | ITER | FIX; it SHALL be 0 in DONE so the pipeline advances that cycle.
REQ-023 result SHALL be registered, SHALL change only on entry to DONE, and SHALL hold until the next DONE.
REQ-024 kill=1 in any non-IDLE state SHALL force IDLE at the next edge, with no done pulse and result unchanged.
REQ-025 kill=1 in DONE SHALL still complete the done pulse, because the result was already produced.
REQ-026 kill and start both high in IDLE SHALL NOT accept the op.
REQ-027 A new start SHALL be accepted on the cycle immediately after DONE (back-to-back), and also on the cycle after a kill.
REQ-028 All internal arithmetic SHALL be 33-bit unsigned on magnitudes; no X or overflow SHALL propagate to result.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state IDLE, busy=0, done=0, result=0, iteration counter=0, and clear the latched operands.
REQ-030 With rst_n=0, stall SHALL be 0 regardless of start.
REQ-031 Reset asserted mid-operation (any state) SHALL abandon the op; no done SHALL follow once reset is released.
REQ-032 The first start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-033 DIVU op1=100, op2=7, start at T -> stall 1 for T..T+34, done=1 and result=14 at T+35; REMU same operands -> result=2.
REQ-034 DIV op1=0xFFFFFFF9 (-7), op2=2 -> result 0xFFFFFFFD (-3) at T+35; REM same operands -> 0xFFFFFFFF (-1).
REQ-035 DIVU 5/0 -> result 0xFFFFFFFF, done at T+2; REMU 5/0 -> result 5, done at T+2.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> result 0x80000000 at T+2; REM same operands -> 0.
REQ-037 DIVU start at T, kill at T+10 -> IDLE and busy=0 at T+11, no done; new DIVU 9/3 at T+11 -> result 3 at T+46.
REQ-038 rst_n=0 at T+20 of an op -> busy=0, result=0 next edge, and no done ever follows; start with func3=000 -> stall=0, busy stays 0.

Source files
------------

// File: rtl/r200_divseq.sv
// Iterative 32-cycle restoring divider for the M-extension DIV/DIVU/REM/REMU ops.
// It holds the execute stage via stall until the DONE state.
module r200_divseq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  logic [XLEN-1:0] op1_q, op2_q;
  logic            rem_op_q, signed_op_q;
  logic            q_neg_q, r_neg_q;
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q;
  logic [5:0]      cnt_q;

  logic            accept;
  logic            div_zero, sgn_ovf;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   shifted, diff;
  logic            q_bit;

  assign accept = start & func3[2] & ~kill;

  always_comb begin
    mag1     = (signed_op_q & op1_q[XLEN-1]) ? (~op1_q + 1'b1) : op1_q;
    mag2     = (signed_op_q & op2_q[XLEN-1]) ? (~op2_q + 1'b1) : op2_q;
    div_zero = (op2_q == '0);
    sgn_ovf  = signed_op_q & (op1_q == INT_MIN) & (op2_q == '1);
  end

  // One restoring step: a borrow out of the 33-bit subtract means the trial failed.
  always_comb begin
    shifted = {rem_q, dvd_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_bit   = ~diff[XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PREP;
      S_PREP: begin
        if (kill)                    state_nxt = S_IDLE;
        else if (div_zero | sgn_ovf) state_nxt = S_DONE;
        else                         state_nxt = S_ITER;
      end
      S_ITER: begin
        if (kill)                    state_nxt = S_IDLE;
        else if (cnt_q == LAST_ITER) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = kill ? S_IDLE : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    stall = 1'b0;
    case (state)
      S_IDLE: stall = rst_n & accept;
      S_PREP,
      S_ITER,
      S_FIX: begin
        busy  = 1'b1;
        stall = rst_n;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // result is written only on the edges that enter DONE, so a kill leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op1_q       <= '0;
      op2_q       <= '0;
      rem_op_q    <= 1'b0;
      signed_op_q <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op1_q       <= op1;
            op2_q       <= op2;
            rem_op_q    <= func3[1];
            signed_op_q <= ~func3[0];
          end
        end
        S_PREP: begin
          if (!kill) begin
            if (div_zero) begin
              result <= rem_op_q ? op1_q : '1;
            end else if (sgn_ovf) begin
              result <= rem_op_q ? '0 : INT_MIN;
            end else begin
              dvd_q   <= mag1;
              dvs_q   <= mag2;
              rem_q   <= '0;
              cnt_q   <= '0;
              q_neg_q <= signed_op_q & (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
              r_neg_q <= signed_op_q & op1_q[XLEN-1];
            end
          end
        end
        S_ITER: begin
          rem_q <= q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          dvd_q <= {dvd_q[XLEN-2:0], q_bit};
          cnt_q <= cnt_q + 6'd1;
        end
        S_FIX: begin
          if (!kill) begin
            if (rem_op_q) result <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
            else          result <= q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
